// File: rtl/motor_driver_regs_s_axi.sv
// AXI4-Lite register slave for the motor driver: four software registers
// (CTRL, DUTY, PERIOD, SCRATCH) plus the PWM and direction output generation.
module motor_driver_regs_s_axi #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              pwm_out,
    output logic                              dir_out
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] new_v,
                                                 input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
            else         r[b*8 +: 8] = old_v[b*8 +: 8];
        end
        return r;
    endfunction

    logic          aw_ready_q, aw_ready_d;
    logic          bvalid_q, bvalid_d;
    logic          ar_ready_q, ar_ready_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    araddr_q, araddr_d;
    logic [DW-1:0] regs_q [4];
    logic [DW-1:0] regs_d [4];
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   duty_sh_q, duty_sh_d;
    logic [15:0]   period_sh_q, period_sh_d;
    logic          pwm_q, pwm_d;
    logic          dir_q, dir_d;
    logic          wr_hs_s, rd_hs_s, en_s;
    logic          unused_s;

    assign wr_hs_s  = aw_ready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_hs_s  = ar_ready_q && S_AXI_ARVALID;
    assign en_s     = regs_q[0][0];
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write channel: AW and W are only ever accepted together, one response outstanding.
    always_comb begin
        regs_d   = regs_q;
        bvalid_d = bvalid_q;
        if (wr_hs_s) begin
            regs_d[S_AXI_AWADDR[3:2]] = apply_strb(regs_q[S_AXI_AWADDR[3:2]], S_AXI_WDATA, S_AXI_WSTRB);
            bvalid_d = 1'b1;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end
        if (!aw_ready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q) aw_ready_d = 1'b1;
        else                                                          aw_ready_d = 1'b0;
    end

    // Read channel: data is captured from the pre-write registers at the handshake edge.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (!ar_ready_q && S_AXI_ARVALID && !rvalid_q) begin
            ar_ready_d = 1'b1;
            araddr_d   = S_AXI_ARADDR[3:2];
        end else begin
            ar_ready_d = 1'b0;
            araddr_d   = araddr_q;
        end
        if (rd_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[araddr_q];
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // PWM: shadows reload only at wrap or while disabled so a period is never cut short.
    always_comb begin
        duty_sh_d   = duty_sh_q;
        period_sh_d = period_sh_q;
        if (!en_s) begin
            cnt_d       = 16'd0;
            duty_sh_d   = regs_q[1][15:0];
            period_sh_d = regs_q[2][15:0];
        end else if (cnt_q >= period_sh_q) begin
            cnt_d       = 16'd0;
            duty_sh_d   = regs_q[1][15:0];
            period_sh_d = regs_q[2][15:0];
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
        pwm_d = en_s && (cnt_q < duty_sh_q);
        dir_d = regs_q[0][1];
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            aw_ready_q  <= 1'b0;
            bvalid_q    <= 1'b0;
            ar_ready_q  <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            araddr_q    <= 2'd0;
            regs_q      <= '{default: '0};
            cnt_q       <= 16'd0;
            duty_sh_q   <= 16'd0;
            period_sh_q <= 16'd0;
            pwm_q       <= 1'b0;
            dir_q       <= 1'b0;
        end else begin
            aw_ready_q  <= aw_ready_d;
            bvalid_q    <= bvalid_d;
            ar_ready_q  <= ar_ready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            araddr_q    <= araddr_d;
            regs_q      <= regs_d;
            cnt_q       <= cnt_d;
            duty_sh_q   <= duty_sh_d;
            period_sh_q <= period_sh_d;
            pwm_q       <= pwm_d;
            dir_q       <= dir_d;
        end
    end

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = aw_ready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign pwm_out       = pwm_q;
    assign dir_out       = dir_q;
endmodule

// File: tb/tb_motor_driver_regs_s_axi.sv
// Self-checking bench for motor_driver_regs_s_axi: register vectors from a table,
// then hand-written sequences for handshake stalls, PWM behaviour and reset.
module tb_motor_driver_regs_s_axi;
    logic        clk;
    logic        S_AXI_ARESETN;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        pwm_out;
    logic        dir_out;

    int n_checks = 0;
    int n_fail   = 0;

    motor_driver_regs_s_axi dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(S_AXI_ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .pwm_out(pwm_out), .dir_out(dir_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        S_AXI_AWADDR  = a;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!S_AXI_AWREADY && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("awready_seen", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        @(posedge clk);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("bvalid", S_AXI_BVALID, 1'b1);
        check("bresp", S_AXI_BRESP, 2'b00);
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!S_AXI_ARREADY && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arready_seen", S_AXI_ARREADY, 1'b1);
        @(posedge clk);
        #1;
        S_AXI_ARVALID = 1'b0;
        check("rvalid", S_AXI_RVALID, 1'b1);
        check("rresp", S_AXI_RRESP, 2'b00);
        d = S_AXI_RDATA;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise();
        int n;
        logic prev;
        prev = pwm_out;
        n = 0;
        @(negedge clk);
        while (!(pwm_out && !prev) && n < 60) begin
            prev = pwm_out;
            @(negedge clk);
            n++;
        end
        check("pwm_rise_seen", pwm_out, 1'b1);
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] rd;
    logic [19:0] pv20;
    logic [29:0] pv30;

    initial begin
        vecs[0] = '{4'h0, 32'h0101FFFF, 4'hF, 32'h0101FFFF};
        vecs[1] = '{4'h4, 32'hABCD0001, 4'hF, 32'hABCD0001};
        vecs[2] = '{4'h8, 32'hDEAD0011, 4'hF, 32'hDEAD0011};
        vecs[3] = '{4'hC, 32'hBEEF0011, 4'hF, 32'hBEEF0011};
        vecs[4] = '{4'hC, 32'h00000000, 4'hF, 32'h00000000};
        vecs[5] = '{4'hC, 32'hFFFFFFFF, 4'h5, 32'h00FF00FF};
        vecs[6] = '{4'hC, 32'h12345678, 4'h0, 32'h00FF00FF};
        vecs[7] = '{4'hD, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5};

        S_AXI_ARESETN = 1'b0;
        S_AXI_AWADDR = 4'h0; S_AXI_AWPROT = 3'd0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        S_AXI_ARADDR = 4'h0; S_AXI_ARPROT = 3'd0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ctrl_outs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                                  S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, pwm_out, dir_out}, 11'd0);
        check("reset_rdata", S_AXI_RDATA, 32'd0);
        S_AXI_ARESETN = 1'b1;
        @(posedge clk);
        #1;

        // Table of write/readback vectors, including strobe masking and ignored low address bits.
        for (int i = 0; i < 8; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            axi_read(vecs[i].addr, rd);
            check($sformatf("readback_%0d", i), rd, vecs[i].exp);
        end

        // AW without W must stall; then a single joint ready; B held off blocks a second write.
        S_AXI_BREADY  = 1'b0;
        S_AXI_AWADDR  = 4'hC;
        S_AXI_WDATA   = 32'h11112222;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("aw_only_no_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
        end
        S_AXI_WVALID = 1'b1;
        @(negedge clk);
        check("joint_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        @(posedge clk);
        #1;
        S_AXI_WDATA = 32'h33334444;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bready_low_hold", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b001);
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        @(posedge clk);
        #1;
        check("bvalid_cleared", S_AXI_BVALID, 1'b0);
        axi_read(4'hC, rd);
        check("stall_write_data", rd, 32'h11112222);

        // PWM PERIOD=9 DUTY=3: three high, seven low per period.
        axi_write(4'h0, 32'h0, 4'hF);
        axi_write(4'h8, 32'd9, 4'hF);
        axi_write(4'h4, 32'd3, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        check("dir_after_ctrl1", dir_out, 1'b0);
        wait_rise();
        pv20[19] = pwm_out;
        for (int i = 18; i >= 0; i--) begin
            @(negedge clk);
            pv20[i] = pwm_out;
        end
        check("pwm_duty3", pv20, 20'b1110000000_1110000000);

        // DUTY changed mid-period only applies from the next wrap.
        wait_rise();
        fork
            begin
                pv30[29] = pwm_out;
                for (int i = 28; i >= 0; i--) begin
                    @(negedge clk);
                    pv30[i] = pwm_out;
                end
            end
            begin
                repeat (2) @(negedge clk);
                axi_write(4'h4, 32'd5, 4'hF);
            end
        join
        check("pwm_duty_change", pv30, 30'b1110000000_1111100000_1111100000);

        // DUTY beyond PERIOD saturates high; disable drops the output right away.
        axi_write(4'h4, 32'd20, 4'hF);
        repeat (15) @(negedge clk);
        for (int i = 19; i >= 0; i--) begin
            @(negedge clk);
            pv20[i] = pwm_out;
        end
        check("pwm_const_high", pv20, 20'hFFFFF);
        axi_write(4'h0, 32'h0, 4'hF);
        check("pwm_low_after_disable", pwm_out, 1'b0);
        axi_write(4'h0, 32'h2, 4'hF);
        check("dir_set", dir_out, 1'b1);
        repeat (2) @(negedge clk);
        check("dir_pwm_ctrl2", {dir_out, pwm_out}, 2'b10);

        // Simultaneous write+read of SCRATCH returns the old value; then reset mid-response.
        @(posedge clk);
        #1;
        S_AXI_BREADY  = 1'b0;
        S_AXI_RREADY  = 1'b0;
        S_AXI_AWADDR  = 4'hC;
        S_AXI_WDATA   = 32'h5A5A5A5A;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_ARADDR  = 4'hC;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("both_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        @(negedge clk);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        check("both_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
        check("read_pre_write", S_AXI_RDATA, 32'h11112222);
        repeat (3) @(negedge clk);
        check("resp_held", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA}, {2'b11, 32'h11112222});
        S_AXI_ARESETN = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_drops_resp", {S_AXI_BVALID, S_AXI_RVALID, pwm_out, dir_out}, 4'b0000);
        check("reset_rdata_mid", S_AXI_RDATA, 32'd0);
        S_AXI_ARESETN = 1'b1;
        S_AXI_BREADY  = 1'b1;
        S_AXI_RREADY  = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd);
            check($sformatf("post_reset_reg_%0d", i), rd, 32'd0);
        end
        check("post_reset_pwm", {pwm_out, dir_out}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/motor_driver_regs_s_axi.md
# motor_driver_regs_s_axi

AXI4-Lite slave (responder) for the motor driver IP: it accepts the register writes and reads issued by the processor-side master and holds four 32-bit software registers. It also generates the motor PWM and direction outputs from those registers. It sits at the AXI slave port of the motor_driver IP, directly behind the interconnect.

## Interface

- C_S_AXI_DATA_WIDTH, 32: data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; bits [3:2] select the register.
- S_AXI_ACLK  in  1  single clock for the bus and the PWM logic.
- S_AXI_ARESETN  in  1  reset, synchronous and active-low.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake.
- pwm_out  out  1  motor PWM.
- dir_out  out  1  motor direction.

## Operation

Register map (byte offset). All registers are fully read/write, and every bit written reads back unchanged.

- 0x0 CTRL: bit0 = enable, bit1 = direction.
- 0x4 DUTY: bits [15:0] = duty count.
- 0x8 PERIOD: bits [15:0] = period count.
- 0xC SCRATCH: no hardware effect.

Write channel:
- AW and W are accepted together, only when AWVALID, WVALID and !BVALID all hold.
- The slave then pulses AWREADY and WREADY together for exactly one cycle.
- The register is updated at the handshake edge, with byte lanes masked by WSTRB.
- Address bits [1:0] are ignored.

Read channel:
- When ARVALID is high and both ARREADY and RVALID are low, the slave pulses ARREADY for one cycle and latches ARADDR.
- RDATA is driven from the latched address.

PWM:
- A 16-bit counter runs while enable=1. It counts 0..PERIOD_shadow, then wraps to 0.
- pwm_out = enable && (cnt < DUTY_shadow). DUTY > PERIOD therefore gives a constant high.
- DUTY_shadow and PERIOD_shadow load from DUTY/PERIOD only at wrap, or while enable=0. This keeps the output glitch-free.
- PERIOD=0: the counter stays at 0, and pwm_out = (DUTY != 0) && enable.
- Writing enable=0 clears the counter and drives pwm_out low on the next cycle.
- dir_out is a registered copy of CTRL bit1.

## Timing

Reset values (when S_AXI_ARESETN=0 at a rising edge):
- All ready/valid outputs = 0; BRESP = RRESP = 0; RDATA = 0.
- All registers, shadows and the counter = 0.
- pwm_out = 0, dir_out = 0.

Write timing:
- Both valids sampled at edge N → AWREADY/WREADY high during cycle N+1.
- Handshake and register update happen at edge N+1.
- BVALID rises at edge N+1 and stays high until a BREADY-high edge clears it.
- Minimum write cost: 3 cycles, valid-to-B-handshake.

Read timing:
- ARVALID sampled at edge N → ARREADY high during N+1.
- RVALID and RDATA are valid from edge N+1 and held stable until an RREADY-high edge.

Channel independence and ordering:
- Read and write channels are independent; a simultaneous read and write are both serviced.
- A read of the same register issued in the same cycle as a write returns the pre-write value.
- If AW arrives without W, the slave waits: no ready is asserted and no partial acceptance occurs.
- At most one outstanding transaction per direction; further requests stall until B or R completes.

Register effects:
- A CTRL write affects dir_out one cycle after the register update.

Reset mid-transaction:
- Reset aborts any in-flight transaction; BVALID/RVALID drop to 0 and the pending response is discarded.

## Test plan

- Reset released, then write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to offsets 0x0/0x4/0x8/0xC; read each back → identical data, BRESP = RRESP = 0.
- Write 0xFFFFFFFF to 0xC with WSTRB=4'b0101, then read → 0x00FF00FF. Write with WSTRB=0 → value unchanged.
- AWVALID asserted 5 cycles before WVALID → no AWREADY until WVALID is high, then a single joint ready pulse. Hold BREADY low 4 cycles → BVALID stays high and no second write is accepted.
- PERIOD=9, DUTY=3, CTRL=1 → pwm_out high 3 cycles and low 7 cycles, repeating. Change DUTY to 5 mid-period → the new duty takes effect only from the next wrap.
- DUTY=20, PERIOD=9 → pwm_out constant high. CTRL=0 → pwm_out low the next cycle. CTRL=2 → dir_out=1 and pwm_out=0.
- Assert reset while BVALID and RVALID are pending → both drop to 0, all registers read 0 after release, pwm_out=0.
